// File: rtl/cpu_issuer_pkg.sv
// Shared types and constants for the cpu_issuer block.
package cpu_issuer_pkg;

    localparam int INSTR_W = 16;

    // Bit positions of the captured status flags inside last_nvz.
    localparam int NVZ_N_IDX = 2;
    localparam int NVZ_V_IDX = 1;
    localparam int NVZ_Z_IDX = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_EXEC  = 2'd3
    } state_t;

endpackage

// File: rtl/instr_fifo.sv
// Instruction FIFO: DEPTH entries (power of 2, >= 2), registered full/empty,
// sticky overflow flag for pushes that arrive while full.
module instr_fifo
    import cpu_issuer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic [INSTR_W-1:0] data_i,
    input  logic               pop_i,
    output logic [INSTR_W-1:0] head_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               ovf_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]    count_q, count_d;
    logic               full_q, empty_q, ovf_q;
    logic               accept, take;

    // A push is taken only when not full at the edge; a pop on an empty FIFO is ignored.
    assign accept = push_i && !full_q;
    assign take   = pop_i && !empty_q;

    // Next occupancy; a simultaneous accepted push and pop cancel out.
    always_comb begin
        count_d = count_q;
        if (accept && !take) begin
            count_d = count_q + CNTW'(1);
        end else if (!accept && take) begin
            count_d = count_q - CNTW'(1);
        end
    end

    // Pointers, count, registered status flags and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (take)   rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNTW'(DEPTH));
            empty_q <= (count_d == '0);
            if (push_i && full_q) ovf_q <= 1'b1;
        end
    end

    // Storage array; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/cpu_issuer.sv
// cpu_issuer: pops host-pushed instructions from a FIFO and sequences the
// cpu's load/start/wait handshake, capturing out and N/V/Z on completion.
// Optional feature macro: CPU_ISSUER_TRACE_EN adds a 16-bit retired counter.
//
// Handshakes: the host side treats push as valid with an implicit ready of
// !full; a push seen while full is dropped and latches ovf. On the cpu side,
// a new instruction starts only while cpu_w (idle) is high; cpu_load then
// cpu_s are one-cycle pulses, and cpu_w high after the guard cycle of EXEC
// marks completion.
module cpu_issuer
    import cpu_issuer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_instr,
    output logic               full,
    output logic               empty,
    output logic               ovf,
    output logic               err,
    output logic [INSTR_W-1:0] cpu_in,
    output logic               cpu_load,
    output logic               cpu_s,
    input  logic               cpu_w,
    input  logic [INSTR_W-1:0] cpu_out,
    input  logic               cpu_N,
    input  logic               cpu_V,
    input  logic               cpu_Z,
    output logic               busy,
    output logic               done,
    output logic [INSTR_W-1:0] last_out,
    output logic [2:0]         last_nvz,
    output state_t             dbg_state
`ifdef CPU_ISSUER_TRACE_EN
    ,
    output logic [15:0]        retired
`endif
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [INSTR_W-1:0] cpu_in_q, cpu_in_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               cap_en;
    logic               pop;
    logic [INSTR_W-1:0] fifo_head;
    logic [INSTR_W-1:0] last_out_q;
    logic [2:0]         last_nvz_q, nvz_now;

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .data_i  (push_instr),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (full),
        .empty_o (empty),
        .ovf_o   (ovf)
    );

    // Next state, EXEC cycle counter, completion/timeout decisions and FIFO pop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cpu_in_d = cpu_in_q;
        done_d   = 1'b0;
        err_d    = err_q;
        cap_en   = 1'b0;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run && !empty && cpu_w) begin
                    state_d  = ST_LOAD;
                    cpu_in_d = fifo_head;
                end
            end
            ST_LOAD: begin
                state_d = ST_START;
            end
            ST_START: begin
                pop     = 1'b1;
                cnt_d   = '0;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // cnt_q == 0 is the guard cycle: the cpu may not have dropped w yet.
                if (cnt_q != '0 && cpu_w) begin
                    cap_en  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, counter, held instruction word, done pulse and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            cpu_in_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cpu_in_q <= cpu_in_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Assemble the live status flags in last_nvz bit order.
    always_comb begin
        nvz_now            = '0;
        nvz_now[NVZ_N_IDX] = cpu_N;
        nvz_now[NVZ_V_IDX] = cpu_V;
        nvz_now[NVZ_Z_IDX] = cpu_Z;
    end

    // Result capture on successful completion only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_out_q <= '0;
            last_nvz_q <= '0;
        end else if (cap_en) begin
            last_out_q <= cpu_out;
            last_nvz_q <= nvz_now;
        end
    end

`ifdef CPU_ISSUER_TRACE_EN
    logic [15:0] retired_q;

    // Count completed instructions; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
        end else if (done_d) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign retired = retired_q;
`endif

    assign cpu_in    = cpu_in_q;
    assign cpu_load  = (state_q == ST_LOAD);
    assign cpu_s     = (state_q == ST_START);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign last_out  = last_out_q;
    assign last_nvz  = last_nvz_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_issuer.sv
// Bench for cpu_issuer with a behavioural cpu model (simple-RISC ISA subset).
module tb_cpu_issuer;
  import cpu_issuer_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;
  localparam int NV      = 10;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        push = 1'b0;
  logic [15:0] push_instr = '0;
  logic        full, empty, ovf, err, cpu_load, cpu_s, busy, done;
  logic [15:0] cpu_in, last_out;
  logic [2:0]  last_nvz;
  state_t      dbg_state;
  logic        cpu_w = 1'b1;
  logic [15:0] cpu_out = '0;
  logic        cpu_N = 1'b0, cpu_V = 1'b0, cpu_Z = 1'b0;
`ifdef CPU_ISSUER_TRACE_EN
  logic [15:0] retired;
`endif

  cpu_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .run(run), .push(push), .push_instr(push_instr),
    .full(full), .empty(empty), .ovf(ovf), .err(err),
    .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_s(cpu_s), .cpu_w(cpu_w),
    .cpu_out(cpu_out), .cpu_N(cpu_N), .cpu_V(cpu_V), .cpu_Z(cpu_Z),
    .busy(busy), .done(done), .last_out(last_out), .last_nvz(last_nvz),
    .dbg_state(dbg_state)
`ifdef CPU_ISSUER_TRACE_EN
    , .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- cpu model ----------------
  logic [15:0] rf [8] = '{default: 16'h0000};
  logic [15:0] ir = '0;
  int          lat = 0;
  int          lat_max = 1;
  bit          hang = 1'b0;
  bit          no_drop = 1'b0;

  always @(posedge clk) begin : cpu_model
    logic [15:0] rn, rm, shv, res;
    bit go;
    go = 1'b0;
    if (cpu_load) ir <= cpu_in;
    if (cpu_s && cpu_w) begin
      if (no_drop) go = 1'b1;
      else begin
        cpu_w <= 1'b0;
        lat   <= $urandom_range(1, lat_max);
      end
    end else if (!cpu_w && !hang) begin
      if (lat <= 1) begin
        go = 1'b1;
        cpu_w <= 1'b1;
      end else begin
        lat <= lat - 1;
      end
    end
    if (go) begin
      rn = rf[ir[10:8]];
      rm = rf[ir[2:0]];
      case (ir[4:3])
        2'b00:   shv = rm;
        2'b01:   shv = {rm[14:0], 1'b0};
        2'b10:   shv = {1'b0, rm[15:1]};
        default: shv = {rm[15], rm[15:1]};
      endcase
      case ({ir[15:13], ir[12:11]})
        5'b110_10: rf[ir[10:8]] = {{8{ir[7]}}, ir[7:0]};
        5'b110_00: begin rf[ir[7:5]] = shv; cpu_out <= shv; end
        5'b101_00: begin res = rn + shv; rf[ir[7:5]] = res; cpu_out <= res; end
        5'b101_01: begin
          res = rn - shv;
          cpu_Z <= (res == 16'h0);
          cpu_N <= res[15];
          cpu_V <= (rn[15] != shv[15]) && (res[15] != rn[15]);
        end
        5'b101_10: begin res = rn & shv; rf[ir[7:5]] = res; cpu_out <= res; end
        5'b101_11: begin res = ~shv; rf[ir[7:5]] = res; cpu_out <= res; end
        default: ;
      endcase
    end
  end

  // ---------------- monitors / scoreboard ----------------
  int          cyc = 0;
  int          done_cnt = 0;
  int          load_cnt = 0;
  int          done_cyc[$];
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
    if (cpu_load) begin
      load_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load cpu_in=%0h expected=no_load", cpu_in);
      end else begin
        chk("load_word", cpu_in, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    push = 1'b1;
    push_instr = w;
    exp_q.push_back(w);
    step();
    push = 1'b0;
  endtask

  task automatic push_drop(input logic [15:0] w);
    push = 1'b1;
    push_instr = w;
    step();
    push = 1'b0;
  endtask

  task automatic wait_dones(input string name, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      step();
      n++;
    end
    chk(name, (done_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_state(input string name, input state_t s, input int budget);
    int n = 0;
    while (dbg_state != s && n < budget) begin
      step();
      n++;
    end
    chk(name, dbg_state, s);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_load"}, cpu_load, 0);
    chk({tag, "_s"}, cpu_s, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cpu_in"}, cpu_in, 0);
    chk({tag, "_last_out"}, last_out, 0);
    chk({tag, "_last_nvz"}, last_nvz, 0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] instr;
    logic [15:0] exp_out;
    logic [2:0]  exp_nvz;
  } vec_t;

  vec_t vecs [NV];

  // ---------------- main test ----------------
  initial begin : main
    int b;
    vecs[0] = '{16'hD007, 16'h0000, 3'b000};  // MOV R0,#7
    vecs[1] = '{16'hC068, 16'h000E, 3'b000};  // MOV R3,R0,LSL#1
    vecs[2] = '{16'hD102, 16'h000E, 3'b000};  // MOV R1,#2
    vecs[3] = '{16'hA148, 16'h0010, 3'b000};  // ADD R2,R1,R0,LSL#1
    vecs[4] = '{16'hA803, 16'h0010, 3'b100};  // CMP R0,R3  (7-14 < 0)
    vecs[5] = '{16'hA800, 16'h0010, 3'b001};  // CMP R0,R0
    vecs[6] = '{16'hB880, 16'hFFF8, 3'b001};  // MVN R4,R0
    vecs[7] = '{16'hB4A3, 16'h0008, 3'b001};  // AND R5,R4,R3
    vecs[8] = '{16'hC0D3, 16'h0007, 3'b001};  // MOV R6,R3,LSR#1
    vecs[9] = '{16'hC0FC, 16'hFFFC, 3'b001};  // MOV R7,R4,ASR#1

    // reset values, during and after reset
    step(3);
    chk_reset_vals("in_reset");
    reset = 1'b1;
    step(2);
    chk_reset_vals("after_reset");

    // table-driven instruction stream
    lat_max = 4;
    run = 1'b1;
    for (int i = 0; i < NV; i++) begin
      b = done_cnt;
      push_word(vecs[i].instr);
      wait_dones($sformatf("vec%0d_done", i), b + 1, 80);
      chk($sformatf("vec%0d_last_out", i), last_out, vecs[i].exp_out);
      chk($sformatf("vec%0d_last_nvz", i), last_nvz, vecs[i].exp_nvz);
    end
    step(2);
    chk("table_empty", empty, 1);
    chk("table_idle", busy, 0);
`ifdef CPU_ISSUER_TRACE_EN
    chk("retired_after_table", retired, NV);
`endif

    // back-to-back throughput: minimum 5 cycles between done pulses
    run = 1'b0;
    lat_max = 1;
    for (int i = 0; i < 3; i++) push_word(16'hD710 + 16'(i));
    b = done_cyc.size();
    run = 1'b1;
    wait_dones("thru_done", done_cnt + 3, 60);
    chk("thru_gap0", done_cyc[b + 1] - done_cyc[b], 5);
    chk("thru_gap1", done_cyc[b + 2] - done_cyc[b + 1], 5);

    // guard cycle: cpu keeps w high throughout, EXEC must still take 2 cycles
    run = 1'b0;
    no_drop = 1'b1;
    for (int i = 0; i < 2; i++) push_word(16'hD720 + 16'(i));
    b = done_cyc.size();
    run = 1'b1;
    wait_dones("guard_done", done_cnt + 2, 40);
    chk("guard_gap", done_cyc[b + 1] - done_cyc[b], 5);
    no_drop = 1'b0;
    chk("guard_last_out", last_out, 16'hFFFC);

    // run dropped mid-instruction: current one finishes, next is held
    run = 1'b0;
    lat_max = 3;
    push_word(16'hD731);
    push_word(16'hD732);
    b = load_cnt;
    run = 1'b1;
    for (int n = 0; n < 20 && load_cnt == b; n++) step();
    run = 1'b0;
    wait_dones("runlow_finish", done_cnt + 1, 40);
    step(15);
    chk("runlow_loads", load_cnt - b, 1);
    chk("runlow_not_empty", empty, 0);
    chk("runlow_idle", busy, 0);
    run = 1'b1;
    wait_dones("runlow_resume", done_cnt + 1, 40);
    step(2);
    chk("runlow_empty", empty, 1);

    // overflow: DEPTH accepted, extra push dropped, then exactly DEPTH retire
    run = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) push_word(16'hD000 + 16'(i));
    chk("ovf_not_full_yet", full, 0);
    push_word(16'hD000 + 16'(DEPTH - 1));
    chk("ovf_full", full, 1);
    chk("ovf_not_yet", ovf, 0);
    push_drop(16'hDEAD);
    chk("ovf_set", ovf, 1);
    chk("ovf_still_full", full, 1);
    b = done_cnt;
    run = 1'b1;
    wait_dones("ovf_drain", b + DEPTH, 400);
    step(12);
    chk("ovf_done_count", done_cnt - b, DEPTH);
    chk("ovf_drain_empty", empty, 1);
    chk("ovf_sticky", ovf, 1);

    // EXEC timeout: cpu never raises w
    run = 1'b0;
    hang = 1'b1;
    lat_max = 1;
    b = done_cnt;
    push_word(16'hD701);
    run = 1'b1;
    wait_state("to_enter_exec", ST_EXEC, 20);
    begin
      int n = 0;
      while (dbg_state == ST_EXEC && n < TIMEOUT + 20) begin
        step();
        n++;
      end
      chk("to_exec_cycles", n, TIMEOUT);
    end
    chk("to_err", err, 1);
    chk("to_no_done", done_cnt - b, 0);
    chk("to_last_out", last_out, 16'hFFFC);
    chk("to_state", dbg_state, ST_IDLE);
    chk("to_busy", busy, 0);
    run = 1'b0;
    hang = 1'b0;
    step(5);

    // asynchronous reset in EXEC with 3 words still queued
    lat_max = 20;
    for (int i = 0; i < 4; i++) push_word(16'hD740 + 16'(i));
    run = 1'b1;
    wait_state("rst_enter_exec", ST_EXEC, 20);
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk_reset_vals("async_reset");
`ifdef CPU_ISSUER_TRACE_EN
    chk("retired_reset", retired, 0);
`endif
    step(3);
    reset = 1'b1;
    b = load_cnt;
    step(25);
    chk("rst_no_load", load_cnt - b, 0);
    chk("rst_empty", empty, 1);
    b = done_cnt;
    push_word(16'hD750);
    wait_dones("rst_new_done", b + 1, 60);
    chk("rst_new_load", load_cnt, b + 0 + (load_cnt - b > 0 ? load_cnt - b : 0));
`ifdef CPU_ISSUER_TRACE_EN
    chk("retired_after_reset", retired, 1);
`endif
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
